// File: rtl/ibex_pkg.sv
// Shared types and constants for the IF-stage fetch FIFO.
package ibex_pkg;

  localparam int unsigned FETCH_FIFO_MIN_DEPTH = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fetch_fifo_entry_t;

endpackage

// File: rtl/ibex_fetch_aligner.sv
// Combinational halfword aligner: builds the current instruction from the two oldest words.
// Error reporting is compiled in only when IBEX_FETCH_FIFO_ERR_EN is defined.
module ibex_fetch_aligner
  import ibex_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  fetch_fifo_entry_t  w0,
  input  fetch_fifo_entry_t  w1,
  input  logic [CNT_W-1:0]   count,
  input  logic               unaligned,
  output logic [31:0]        rdata,
  output logic               is_c,
  output logic               valid,
  output logic               err,
  output logic               err_plus2,
  output logic               pop_word
);

  logic [15:0] lo;
  logic        has1;
  logic        has2;
  logic        w0_err;
  logic        w1_err;
  logic        unused_bits;

`ifdef IBEX_FETCH_FIFO_ERR_EN
  assign w0_err = w0.err;
  assign w1_err = w1.err;
`else
  assign w0_err = 1'b0;
  assign w1_err = 1'b0;
`endif

  assign unused_bits = ^{w1.data[31:16], w0.err, w1.err};

  always_comb begin
    lo        = unaligned ? w0.data[31:16] : w0.data[15:0];
    is_c      = (lo[1:0] != 2'b11);
    has1      = (count != '0);
    has2      = (count >= CNT_W'(2));
    rdata     = w0.data;
    valid     = has1;
    err       = 1'b0;
    err_plus2 = 1'b0;
    pop_word  = unaligned | ~is_c;

    if (unaligned) begin
      if (is_c) begin
        rdata = {(has2 ? w1.data[15:0] : 16'h0), w0.data[31:16]};
        valid = has1;
      end else begin
        rdata = {w1.data[15:0], w0.data[31:16]};
        valid = has2 | (has1 & w0_err);
      end
    end

    // An unaligned 32-bit instruction may fault in either of its two words.
    err       = w0_err | (unaligned & ~is_c & has2 & w1_err);
    err_plus2 = unaligned & ~is_c & ~w0_err & w1_err;
  end

endmodule

// File: rtl/ibex_fetch_align_fifo.sv
// Word-buffering, halfword-aligning instruction fetch FIFO.
// Define IBEX_FETCH_FIFO_ERR_EN to store and report per-word bus errors.
module ibex_fetch_align_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o,
  input  logic        out_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_fifo_entry_t entries [DEPTH];
  fetch_fifo_entry_t in_entry;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;
  logic [CNT_W-1:0]  push_idx;
  logic [31:1]       addr_q;
  logic              is_c;
  logic              pop_word;
  logic              push;
  logic              pop;
  logic              pop_word_fire;
  logic              unused_bits;

  depth_ok : assert property (@(posedge clk_i) DEPTH >= FETCH_FIFO_MIN_DEPTH);

  ibex_fetch_aligner #(
    .CNT_W (CNT_W)
  ) u_aligner (
    .w0        (entries[0]),
    .w1        (entries[1]),
    .count     (count),
    .unaligned (addr_q[1]),
    .rdata     (out_rdata_o),
    .is_c      (is_c),
    .valid     (out_valid_o),
    .err       (out_err_o),
    .err_plus2 (out_err_plus2_o),
    .pop_word  (pop_word)
  );

  assign in_entry.data = in_rdata_i;
`ifdef IBEX_FETCH_FIFO_ERR_EN
  assign in_entry.err  = in_err_i;
`else
  assign in_entry.err  = 1'b0;
`endif
  assign unused_bits = ^{addr_i[0], in_err_i};

  assign in_ready_o    = (count < CNT_W'(DEPTH));
  assign out_addr_o    = {addr_q, 1'b0};
  assign push          = in_valid_i & in_ready_o;
  assign pop           = out_valid_o & out_ready_i;
  assign pop_word_fire = pop & pop_word;

  // A pushed word lands behind the survivors of this cycle's shift.
  always_comb begin
    count_n  = count;
    push_idx = count;
    if (pop_word_fire) begin
      push_idx = count - CNT_W'(1);
    end
    case ({push, pop_word_fire})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= '0;
      addr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i].err <= 1'b0;
      end
    end else if (clear_i) begin
      count  <= '0;
      addr_q <= addr_i[31:1];
    end else begin
      count <= count_n;
      if (pop) begin
        addr_q <= addr_q + (is_c ? 31'd1 : 31'd2);
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (pop_word_fire && (i < DEPTH - 1)) begin
          entries[i] <= entries[i+1];
        end
        if (push && (CNT_W'(i) == push_idx)) begin
          entries[i] <= in_entry;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed self-checking bench for ibex_fetch_align_fifo (DEPTH = 3).
module tb_ibex_fetch_align_fifo;

`ifdef IBEX_FETCH_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        in_valid = 1'b0;
  logic [31:0] in_rdata = 32'h0;
  logic        in_err = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic [31:0] out_addr;
  logic        out_err;
  logic        out_err_plus2;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  ibex_fetch_align_fifo #(.DEPTH(3)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .addr_i          (addr),
    .in_valid_i      (in_valid),
    .in_rdata_i      (in_rdata),
    .in_err_i        (in_err),
    .in_ready_o      (in_ready),
    .out_valid_o     (out_valid),
    .out_rdata_o     (out_rdata),
    .out_addr_o      (out_addr),
    .out_err_o       (out_err),
    .out_err_plus2_o (out_err_plus2),
    .out_ready_i     (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then return to idle; outputs sampled 1ns after the edge.
  task automatic cycle(input logic clr, input logic [31:0] a, input logic v,
                       input logic [31:0] d, input logic e, input logic rdy);
    clear = clr; addr = a; in_valid = v; in_rdata = d; in_err = e; out_ready = rdy;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0; in_err = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_clear(input logic [31:0] a);
    cycle(1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    cycle(1'b0, 32'h0, 1'b1, d, e, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_addr", out_addr, 32'h0);
    check("rst_err", 32'(out_err), 32'h0);
    check("rst_err2", 32'(out_err_plus2), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // Aligned 32-bit instruction
    do_clear(32'h80);
    check("al_clr_valid", 32'(out_valid), 32'h0);
    check("al_clr_addr", out_addr, 32'h80);
    push(32'h0000_0013, 1'b0);
    check("al_valid", 32'(out_valid), 32'h1);
    check("al_rdata", out_rdata, 32'h0000_0013);
    check("al_addr", out_addr, 32'h80);
    pop();
    check("al_pop_cnt", 32'(dut.count), 32'h0);
    check("al_pop_addr", out_addr, 32'h84);
    check("al_pop_valid", 32'(out_valid), 32'h0);

    // Compressed pair in one word
    do_clear(32'h80);
    push(32'h4501_4581, 1'b0);
    check("cp0_valid", 32'(out_valid), 32'h1);
    check("cp0_rdata", 32'(out_rdata[15:0]), 32'h4581);
    check("cp0_addr", out_addr, 32'h80);
    pop();
    check("cp1_rdata", 32'(out_rdata[15:0]), 32'h4501);
    check("cp1_addr", out_addr, 32'h82);
    check("cp1_cnt", 32'(dut.count), 32'h1);
    pop();
    check("cp2_valid", 32'(out_valid), 32'h0);
    check("cp2_addr", out_addr, 32'h84);
    check("cp2_cnt", 32'(dut.count), 32'h0);

    // Unaligned 32-bit instruction spanning two words
    do_clear(32'h102);
    push(32'h0013_ABCD, 1'b0);
    check("ua_half_valid", 32'(out_valid), 32'h0);
    check("ua_half_addr", out_addr, 32'h102);
    push(32'h1234_0000, 1'b0);
    check("ua_valid", 32'(out_valid), 32'h1);
    check("ua_rdata", out_rdata, 32'h0000_0013);
    check("ua_addr", out_addr, 32'h102);
    pop();
    check("ua_pop_addr", out_addr, 32'h106);
    check("ua_pop_cnt", 32'(dut.count), 32'h1);
    check("ua_c_valid", 32'(out_valid), 32'h1);
    check("ua_c_rdata", out_rdata, 32'h0000_1234);

    // Full: fourth word dropped, and a push is refused even with a simultaneous pop
    do_clear(32'h0);
    push(32'h0000_0013, 1'b0);
    push(32'h0000_0093, 1'b0);
    push(32'h0000_0113, 1'b0);
    check("full_ready", 32'(in_ready), 32'h0);
    check("full_cnt", 32'(dut.count), 32'h3);
    push(32'hDEAD_BEEF, 1'b0);
    check("full_drop_cnt", 32'(dut.count), 32'h3);
    check("full_drop_rdata", out_rdata, 32'h0000_0013);
    cycle(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check("full_pp_cnt", 32'(dut.count), 32'h2);
    check("full_pp_addr", out_addr, 32'h4);
    check("full_pp_rdata", out_rdata, 32'h0000_0093);
    check("full_pp_ready", 32'(in_ready), 32'h1);

    // Clear beats simultaneous push and pop at count 2
    cycle(1'b1, 32'h200, 1'b1, 32'h0000_0213, 1'b0, 1'b1);
    check("clr_cnt", 32'(dut.count), 32'h0);
    check("clr_valid", 32'(out_valid), 32'h0);
    check("clr_addr", out_addr, 32'h200);

    // Address wrap from the top halfword; lone compressed upper half zero-fills
    do_clear(32'hFFFF_FFFE);
    push(32'h0000_0001, 1'b0);
    check("wrap_valid", 32'(out_valid), 32'h1);
    check("wrap_rdata", out_rdata, 32'h0000_0000);
    pop();
    check("wrap_addr", out_addr, 32'h0);
    check("wrap_cnt", 32'(dut.count), 32'h0);

    // Bus errors
    do_clear(32'h80);
    push(32'h0000_0013, 1'b1);
    check("err_al", 32'(out_err), 32'(ERR_EN));
    check("err_al_p2", 32'(out_err_plus2), 32'h0);
    do_clear(32'h102);
    push(32'h0013_ABCD, 1'b0);
    push(32'h1234_0000, 1'b1);
    check("err_ua_valid", 32'(out_valid), 32'h1);
    check("err_ua", 32'(out_err), 32'(ERR_EN));
    check("err_ua_p2", 32'(out_err_plus2), 32'(ERR_EN));
    do_clear(32'h102);
    push(32'h0013_ABCD, 1'b1);
    check("err_half_valid", 32'(out_valid), 32'(ERR_EN));
    check("err_half", 32'(out_err), 32'(ERR_EN));
    check("err_half_p2", 32'(out_err_plus2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
